iter_divider: RTL and testbench

//  Multi-cycle 32-bit integer divider for the MIPS DIV/DIVU path; the slow counterpart of the single-cycle ALU.

---
 rtl/iter_divider_if.sv | 25 ++
 rtl/iter_divider.sv | 99 +++++++++
 tb/tb_iter_divider.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/iter_divider_if.sv
// rtl/iter_divider_if.sv - request/response handshake bundle for the iterative divider
interface iter_divider_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  div_valid;
  logic                  div_ready;
  logic                  div_signed;
  logic [DATA_WIDTH-1:0] div_a;
  logic [DATA_WIDTH-1:0] div_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  div_by_zero;

  modport master (
    output div_valid, div_signed, div_a, div_b, res_ready,
    input  div_ready, res_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  div_valid, div_signed, div_a, div_b, res_ready,
    output div_ready, res_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle restoring divider for DIV/DIVU, quotient to LO, remainder to HI
module iter_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  iter_divider_if.slave   dif
);
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] b_mag, q, rem, raw_a;
  logic [DATA_WIDTH-1:0] quo_r, rem_r;
  logic                  q_neg, r_neg, zero, dbz_r;
  logic [CW-1:0]         cnt;

  logic                  accept, last, ge;
  logic                  a_neg_in, b_neg_in;
  logic [DATA_WIDTH:0]   trial, diff;
  logic [DATA_WIDTH-1:0] q_step, rem_step;

  assign a_neg_in = dif.div_signed & dif.div_a[DATA_WIDTH-1];
  assign b_neg_in = dif.div_signed & dif.div_b[DATA_WIDTH-1];
  assign accept   = (state == IDLE) & dif.div_valid;
  assign last     = (state == CALC) & (cnt == CW'(DATA_WIDTH - 1));

  // Partial remainder is one bit wider than the divisor for the trial subtract.
  assign trial    = {rem, q[DATA_WIDTH-1]};
  assign diff     = trial - {1'b0, b_mag};
  assign ge       = (trial >= {1'b0, b_mag});
  assign rem_step = ge ? diff[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
  assign q_step   = {q[DATA_WIDTH-2:0], ge};

  assign dif.quotient    = quo_r;
  assign dif.remainder   = rem_r;
  assign dif.div_by_zero = dbz_r;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    dif.div_ready = 1'b0;
    dif.res_valid = 1'b0;
    case (state)
      IDLE: begin
        dif.div_ready = 1'b1;
        if (dif.div_valid) state_nxt = CALC;
      end
      CALC: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        dif.res_valid = 1'b1;
        if (dif.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_mag <= '0;
      q     <= '0;
      rem   <= '0;
      raw_a <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      zero  <= 1'b0;
      cnt   <= '0;
      quo_r <= '0;
      rem_r <= '0;
      dbz_r <= 1'b0;
    end else if (accept) begin
      q     <= a_neg_in ? -dif.div_a : dif.div_a;
      b_mag <= b_neg_in ? -dif.div_b : dif.div_b;
      rem   <= '0;
      raw_a <= dif.div_a;
      q_neg <= a_neg_in ^ b_neg_in;
      r_neg <= a_neg_in;
      zero  <= (dif.div_b == '0);
      cnt   <= '0;
    end else if (state == CALC) begin
      q   <= q_step;
      rem <= rem_step;
      cnt <= cnt + CW'(1);
      if (last) begin
        // Divide by zero reports all-ones quotient and the untouched dividend.
        quo_r <= zero ? '1    : (q_neg ? -q_step   : q_step);
        rem_r <= zero ? raw_a : (r_neg ? -rem_step : rem_step);
        dbz_r <= zero;
      end
    end
  end
endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - randomized self-checking bench for iter_divider against an arithmetic model
module tb_iter_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  iter_divider_if #(.DATA_WIDTH(32)) dif ();

  iter_divider #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Truncating division in 64-bit arithmetic so the signed overflow case needs no special handling.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint la, lb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (s) begin
      la = {{32{a[31]}}, a};
      lb = {{32{b[31]}}, b};
      q  = 32'(la / lb);
      r  = 32'(la % lb);
      z  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  task automatic scramble_inputs(input logic with_ready);
    dif.div_valid  = 1'($urandom);
    dif.div_signed = 1'($urandom);
    dif.div_a      = $urandom;
    dif.div_b      = $urandom;
    dif.res_ready  = with_ready ? 1'($urandom) : 1'b0;
  endtask

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] eq, er;
    logic        ez;
    int          lat;
    model(s, a, b, eq, er, ez);
    lat = 0;
    while (!dif.div_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("ready_before_req", dif.div_ready, 1);
    dif.div_valid  = 1'b1;
    dif.div_signed = s;
    dif.div_a      = a;
    dif.div_b      = b;
    @(negedge clk);
    check("busy_after_accept", dif.div_ready, 0);
    lat = 0;
    while (!dif.res_valid && lat < 40) begin
      scramble_inputs(1'b1);
      @(negedge clk);
      lat++;
      if (dif.div_ready && dif.res_valid) check("ready_valid_overlap", 1, 0);
    end
    dif.res_ready = 1'b0;
    check("latency", lat, 32);
    check("quotient", dif.quotient, eq);
    check("remainder", dif.remainder, er);
    check("div_by_zero", dif.div_by_zero, ez);
    check("ready_in_done", dif.div_ready, 0);
    for (int i = 0; i < hold; i++) begin
      scramble_inputs(1'b0);
      @(negedge clk);
      check("hold_valid", dif.res_valid, 1);
      check("hold_ready", dif.div_ready, 0);
      check("hold_quotient", dif.quotient, eq);
      check("hold_remainder", dif.remainder, er);
    end
    dif.div_valid = 1'b0;
    dif.res_ready = 1'b1;
    @(negedge clk);
    dif.res_ready = 1'b0;
    check("valid_drop", dif.res_valid, 0);
    check("ready_return", dif.div_ready, 1);
    check("idle_hold_quotient", dif.quotient, eq);
    check("idle_hold_remainder", dif.remainder, er);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    dif.div_valid  = 1'b0;
    dif.div_signed = 1'b0;
    dif.div_a      = '0;
    dif.div_b      = '0;
    dif.res_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_div_ready", dif.div_ready, 1);
    check("rst_res_valid", dif.res_valid, 0);
    check("rst_quotient", dif.quotient, 0);
    check("rst_remainder", dif.remainder, 0);
    check("rst_div_by_zero", dif.div_by_zero, 0);

    run_div(1'b0, 32'd100, 32'd7, 0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_div(1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    run_div(1'b0, 32'd5, 32'd0, 0);
    run_div(1'b0, 32'd6, 32'd3, 0);
    run_div(1'b1, 32'h8000_0001, 32'd0, 0);
    run_div(1'b0, 32'd100, 32'd7, 10);

    // Abort an in-flight division with reset partway through the iterations.
    dif.div_valid  = 1'b1;
    dif.div_signed = 1'b0;
    dif.div_a      = 32'hFFFF_FFFF;
    dif.div_b      = 32'd3;
    @(negedge clk);
    dif.div_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_div_ready", dif.div_ready, 1);
    check("abort_res_valid", dif.res_valid, 0);
    check("abort_quotient", dif.quotient, 0);
    check("abort_remainder", dif.remainder, 0);
    check("abort_div_by_zero", dif.div_by_zero, 0);
    run_div(1'b0, 32'd9, 32'd4, 0);

    for (int n = 0; n < 40; n++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_div(rs, ra, rb, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
